bus_dev_port: RTL and testbench

// - Device-side endpoint of the bs_gnrtr_n_rbtr bus: the opposite end of the pndng/pop/D_pop/push/D_push handshake.
// - TX FIFO: host enqueues packets; offered to the arbiter via pndng/D_pop, removed on pop.
// - RX FIFO: captures packets pushed by the bus (own ID or broadcast); host drains it.
// - One instance per device (drvrs instances per bus). Replaces the behavioural driver/monitor queue with synthesizable RTL.

---
 rtl/bus_dev_pkg.sv | 15 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/bus_dev_port.sv | 96 +++++++++
 tb/tb_bus_dev_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device port.
//   ID_W      : width of the destination-ID field at the top of every packet
//   MAX_PKT_W : widest packet get_dest() accepts (callers zero-extend to this)
//   get_dest  : extracts the destination ID from a packet of width pkt_w
package bus_dev_pkg;

  localparam int ID_W      = 8;
  localparam int MAX_PKT_W = 64;

  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                               input int                   pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   wr, wr_data     : enqueue strobe and data (accepted if not full, or if a
//                     read in the same cycle frees a slot)
//   rd, rd_data     : dequeue strobe (ignored while empty) and current head
//   full, empty     : occupancy flags
//   count           : number of stored entries, 0..depth
module sync_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [width-1:0]           wr_data,
  input  logic                       rd,
  output logic [width-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_eff;
  logic             rd_eff;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // A read on a full FIFO is always effective (depth >= 2), so it may free the
  // slot that a simultaneous write lands in.
  assign rd_eff = rd & ~empty;
  assign wr_eff = wr & (~full | rd_eff);

  // NOTE: the storage array has no reset; only pointers and count define
  // validity, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_eff) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_eff) wr_ptr <= wr_ptr + AW'(1);
      if (rd_eff) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_eff, rd_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side endpoint of the bus arbiter handshake.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   pndng, D_pop, pop : TX offer to the bus (FWFT head) and bus consume strobe
//   push, D_push      : packet delivered by the bus
//   tx_wr, tx_data    : host enqueue into TX;  tx_full when TX has no room
//   rx_rd, rx_data    : host dequeue from RX (FWFT head); rx_empty flag
//   err               : sticky {rx_ovf, tx_ovf, pop_unf}, cleared by reset only
//   drop_cnt          : saturating count of pushes not stored (misaddressed/full)
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int unsigned    pckg_sz   = 16,
  parameter int unsigned    depth     = 8,
  parameter logic [ID_W-1:0] dev_id    = 8'h00,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [2:0]         err,
  output logic [7:0]         drop_cnt
);

  logic                   tx_empty;
  logic                   rx_full;
  logic [$clog2(depth):0] tx_count;
  logic [$clog2(depth):0] rx_count;
  logic [ID_W-1:0]        rx_dest;
  logic                   addr_ok;
  logic                   rx_wr;
  logic                   rx_ovf;
  logic                   tx_ovf;
  logic                   pop_unf;
  logic                   drop_evt;

  // Occupancy counts are informational here; the flags carry all decisions.
  logic unused_counts;
  assign unused_counts = ^{tx_count, rx_count};

  sync_fifo #(.width(pckg_sz), .depth(depth)) tx_q (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  assign pndng = ~tx_empty;

  assign rx_dest = get_dest(MAX_PKT_W'(D_push), pckg_sz);
  assign addr_ok = (rx_dest == dev_id) || (rx_dest == broadcast);
  assign rx_wr   = push & addr_ok;

  sync_fifo #(.width(pckg_sz), .depth(depth)) rx_q (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .wr_data (D_push),
    .rd      (rx_rd),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // Overflow only when no same-cycle read/pop frees a slot.
  assign rx_ovf   = rx_wr & rx_full & ~rx_rd;
  assign tx_ovf   = tx_wr & tx_full & ~pop;
  assign pop_unf  = pop & tx_empty;
  assign drop_evt = (push & ~addr_ok) | rx_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= '0;
      drop_cnt <= '0;
    end else begin
      err <= err | {rx_ovf, tx_ovf, pop_unf};
      if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Self-checking bench for bus_dev_port (pckg_sz=16, depth=8, dev_id=3).
// A vector table covers single-cycle behaviour; hand-written sequences cover
// FIFO fill/overflow, simultaneous read/write at full, mid-traffic reset and
// drop counter saturation.
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        tx_wr;
  logic [15:0] tx_data;
  logic        tx_full;
  logic        rx_rd;
  logic [15:0] rx_data;
  logic        rx_empty;
  logic [2:0]  err;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'h03), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .rx_rd    (rx_rd),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .err      (err),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rx_rd;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic        e_full;
    logic        e_rxe;
    logic [15:0] e_rxd;
    logic [2:0]  e_err;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; tx_wr = 1'b0; tx_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rx_rd = 1'b0;
  endtask

  // Inputs are held through one rising edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step();
  endtask

  initial begin
    idle();
    @(negedge clk);

    //            rst wr data     pop psh d_push   rd   pndng dpop     full rxe rxd      err     drop
    vecs[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b000,8'd0};
    vecs[1]  = '{1'b0,1'b1,16'h0312,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0312,1'b0,1'b1,16'h0000,3'b000,8'd0};
    vecs[2]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b000,8'd0};
    vecs[3]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b001,8'd0};
    vecs[4]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h03AA,1'b0, 1'b0,16'h0000,1'b0,1'b0,16'h03AA,3'b001,8'd0};
    vecs[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'hFF55,1'b0, 1'b0,16'h0000,1'b0,1'b0,16'h03AA,3'b001,8'd0};
    vecs[6]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0711,1'b0, 1'b0,16'h0000,1'b0,1'b0,16'h03AA,3'b001,8'd1};
    vecs[7]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0000,1'b0,1'b0,16'hFF55,3'b001,8'd1};
    vecs[8]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b001,8'd1};
    vecs[9]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b001,8'd1};
    vecs[10] = '{1'b0,1'b1,16'h0A01,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0A01,1'b0,1'b1,16'h0000,3'b001,8'd1};
    vecs[11] = '{1'b0,1'b1,16'h0A02,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0A01,1'b0,1'b1,16'h0000,3'b001,8'd1};
    vecs[12] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0A02,1'b0,1'b1,16'h0000,3'b001,8'd1};
    vecs[13] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b001,8'd1};
    vecs[14] = '{1'b1,1'b1,16'h0BBB,1'b1,1'b1,16'h0711,1'b1, 1'b0,16'h0000,1'b0,1'b1,16'h0000,3'b000,8'd0};

    for (int i = 0; i < 15; i++) begin
      reset = vecs[i].rst; tx_wr = vecs[i].tx_wr; tx_data = vecs[i].tx_data;
      pop = vecs[i].pop; push = vecs[i].push; D_push = vecs[i].d_push; rx_rd = vecs[i].rx_rd;
      step();
      check($sformatf("v%0d pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
      if (vecs[i].e_pndng) check($sformatf("v%0d D_pop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
      check($sformatf("v%0d tx_full", i), 32'(tx_full), 32'(vecs[i].e_full));
      check($sformatf("v%0d rx_empty", i), 32'(rx_empty), 32'(vecs[i].e_rxe));
      if (!vecs[i].e_rxe) check($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(vecs[i].e_rxd));
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
      check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
    end

    // TX fill: 9 writes, 9th dropped; then write+pop on full; drain in order.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tx_wr = 1'b1; tx_data = 16'h1000 + 16'(i);
      step();
      check($sformatf("fill%0d tx_full", i), 32'(tx_full), 32'(i >= 7));
    end
    check("tx_ovf err", 32'(err), 32'b010);
    tx_wr = 1'b1; tx_data = 16'h2000; pop = 1'b1;
    step();
    check("full wr+pop tx_full", 32'(tx_full), 32'd1);
    check("full wr+pop err", 32'(err), 32'b010);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_d;
      exp_d = (i < 7) ? 16'h1001 + 16'(i) : 16'h2000;
      check($sformatf("drain%0d pndng", i), 32'(pndng), 32'd1);
      check($sformatf("drain%0d D_pop", i), 32'(D_pop), 32'(exp_d));
      pop = 1'b1;
      step();
    end
    check("drained pndng", 32'(pndng), 32'd0);

    // RX full, then push+read same cycle, then push alone.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'h0300 + 16'(i);
      step();
    end
    check("rx fill rx_data", 32'(rx_data), 32'h0300);
    push = 1'b1; D_push = 16'h03F0; rx_rd = 1'b1;
    step();
    check("rx push+rd err", 32'(err), 32'b000);
    check("rx push+rd drop", 32'(drop_cnt), 32'd0);
    push = 1'b1; D_push = 16'hFFF1;
    step();
    check("rx ovf err", 32'(err), 32'b100);
    check("rx ovf drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_d;
      exp_d = (i < 7) ? 16'h0301 + 16'(i) : 16'h03F0;
      check($sformatf("rx drain%0d", i), 32'(rx_data), 32'(exp_d));
      rx_rd = 1'b1;
      step();
    end
    check("rx drained empty", 32'(rx_empty), 32'd1);

    // Mid-traffic reset with 5 TX / 3 RX entries and live error/drop state.
    do_reset();
    pop = 1'b1; push = 1'b1; D_push = 16'h0900;
    step();
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1'b1; tx_data = 16'h4000 + 16'(i);
      if (i < 3) begin push = 1'b1; D_push = 16'h0350 + 16'(i); end
      step();
    end
    check("pre-reset err", 32'(err), 32'b001);
    check("pre-reset drop", 32'(drop_cnt), 32'd1);
    do_reset();
    check("mid rst pndng", 32'(pndng), 32'd0);
    check("mid rst rx_empty", 32'(rx_empty), 32'd1);
    check("mid rst err", 32'(err), 32'd0);
    check("mid rst drop", 32'(drop_cnt), 32'd0);

    // Drop counter saturation with 300 misaddressed pushes.
    for (int i = 0; i < 300; i++) begin
      push = 1'b1; D_push = 16'h0500 + 16'(i[7:0]);
      step();
      if (i == 253) check("drop 254", 32'(drop_cnt), 32'hFE);
    end
    check("drop sat", 32'(drop_cnt), 32'hFF);
    check("drop sat rx_empty", 32'(rx_empty), 32'd1);
    check("drop sat err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
